// File: rtl/rom_sched_pkg.sv
// Shared types and helpers for the ROM port-B burst scheduler.
// Holds the FSM state type, default burst field width and one-hot helper.
package rom_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int LEN_W_DEF = 5;
    localparam int NREQ_MAX  = 8;

    // Requester id to one-hot select, sized for the largest supported NREQ.
    function automatic logic [NREQ_MAX-1:0] onehot(input logic [2:0] id);
        logic [NREQ_MAX-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rom_burst_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
// Produces the winner index and a flag saying any request is present.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  win,
    output logic            any
);

    int idx;

    // Scan from the farthest offset down so the nearest request to ptr wins.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NREQ;
            if (req[idx]) begin
                win = IDW'(idx);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_burst_sched.sv
// Burst sequencer and round-robin arbiter for ROM port B.
// Grants one burst at a time and steers returned words to the owner.
module rom_burst_sched
    import rom_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int SIZE  = 2048,
    parameter int WIDTH = 16,
    parameter int ASIZE = $clog2(SIZE),
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*ASIZE-1:0] req_addr,
    input  logic [NREQ*LEN_W-1:0] req_len,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       rvalid,
    output logic                  rlast,
    output logic [WIDTH-1:0]      rdata,
    output logic                  busy,
    output logic                  rom_en_b,
    output logic [ASIZE-1:0]      rom_addr_b,
    input  logic [WIDTH-1:0]      rom_dout_b
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   rr_q;
    logic [IDW-1:0]   gnt_q;
    logic [ASIZE-1:0] base_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] k_q;

    logic             issue_q;
    logic             last_q;
    logic [IDW-1:0]   rid_q;

    logic [IDW-1:0]   win;
    logic             any;
    logic             issue;
    logic             last_issue;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req  (req),
        .ptr  (rr_q),
        .win  (win),
        .any  (any)
    );

    assign issue      = (state_q == BURST);
    assign last_issue = issue && (k_q == len_q);

    // Next-state logic: leave IDLE on any request, leave BURST after word len.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (k_q == len_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Issue-side outputs: ROM enable/address and the first-cycle ack pulse.
    always_comb begin
        rom_en_b   = 1'b0;
        rom_addr_b = '0;
        ack        = '0;
        if (issue) begin
            rom_en_b   = 1'b1;
            rom_addr_b = base_q + ASIZE'(k_q);
            if (k_q == '0) begin
                ack = NREQ'(onehot(3'(gnt_q)));
            end
        end
    end

    // Grant capture, burst word counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (any) begin
                    gnt_q  <= win;
                    base_q <= req_addr[int'(win)*ASIZE +: ASIZE];
                    len_q  <= req_len[int'(win)*LEN_W +: LEN_W];
                    k_q    <= '0;
                    if (win == IDW'(NREQ - 1)) begin
                        rr_q <= '0;
                    end else begin
                        rr_q <= win + 1'b1;
                    end
                end
            end else begin
                k_q <= k_q + 1'b1;
            end
        end
    end

    // Return pipeline aligned with the ROM's one-cycle registered read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_q <= 1'b0;
            last_q  <= 1'b0;
            rid_q   <= '0;
        end else begin
            issue_q <= issue;
            last_q  <= last_issue;
            rid_q   <= gnt_q;
        end
    end

    // Return-side qualifiers steer the shared data bus to the owner only.
    always_comb begin
        rvalid = '0;
        if (issue_q) begin
            rvalid = NREQ'(onehot(3'(rid_q)));
        end
        rlast = issue_q & last_q;
        rdata = rom_dout_b;
        busy  = issue | issue_q;
    end

endmodule

// File: doc/rom_burst_sched.md
# rom_burst_sched

Burst sequencer and round-robin arbiter that shares port B of the sprite/tile dual-port ROM between several fetch engines, e.g. player, exit and wall sprite line fetchers. Port A stays dedicated to the VGA pixel path. Each requester asks for a burst of consecutive ROM words. The block grants one burst at a time, drives the ROM port-B enable/address sequence, and steers returning words back to the owner with valid/last qualifiers.

## Interface
- NREQ, 4: number of requesters (2..8)
- SIZE, 2048: ROM depth in words
- WIDTH, 16: ROM word width
- ASIZE, $clog2(SIZE): address width
- LEN_W, 5: burst length field width; burst length = req_len+1 (1..2^LEN_W words)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req  in  NREQ  per-requester burst request, level
- req_addr  in  NREQ×ASIZE  burst base address per requester
- req_len  in  NREQ×LEN_W  burst length minus one per requester
- ack  out  NREQ  one-cycle pulse: burst accepted, req_addr/req_len captured
- rvalid  out  NREQ  one-hot: rdata is a word for that requester
- rlast  out  1  qualifies the final word of the burst (with rvalid)
- rdata  out  WIDTH  returned ROM word (shared bus)
- busy  out  1  a burst is issuing or its final word is still in flight
- rom_en_b  out  1  ROM port-B enable
- rom_addr_b  out  ASIZE  ROM port-B address
- rom_dout_b  in  WIDTH  ROM port-B data (1-cycle registered read)

## Operation
- FSM states: IDLE, BURST.
- IDLE, some req set:
  - Pick the winner by round-robin, starting at pointer rr_q.
  - Capture the winner's id, req_addr and req_len into registers.
  - Move to BURST.
  - Advance rr_q to (winner+1) mod NREQ.
- IDLE, no req: stay in IDLE, rr_q unchanged.
- BURST:
  - Each cycle: rom_en_b=1, rom_addr_b=base+k, ack[id]=1 on the first cycle only.
  - k runs 0..len.
  - After issuing k=len, return to IDLE.
- Address arithmetic is ASIZE bits. base+k wraps modulo 2^ASIZE, e.g. 2047 is followed by 0. There is no range check against SIZE.
- Return path is a one-stage pipeline:
  - issue_q, last_q and id_q are registered from the issue cycle.
  - rvalid = issue_q ? onehot(id_q) : 0.
  - rlast = issue_q & last_q.
  - rdata = rom_dout_b, passed through.
- Requesters:
  - Must hold req, req_addr and req_len stable until ack.
  - After ack, a requester may drop req or change its fields. Deasserting req mid-burst does not abort the burst.
  - If req is still high after ack, it is a new request at the next IDLE.
- Only the grant owner ever sees rvalid. rvalid is never multi-hot.
- Reset: state=IDLE, rr_q=0, issue_q=0. All outputs are 0: ack, rvalid, rlast, busy, rom_en_b, rom_addr_b and rdata-qualifiers.
- Reset asserted mid-burst: the burst is discarded and no further rvalid is produced, including for a word already issued. No ack is replayed.

## Timing
- Cycle T0 is the IDLE cycle with req sampled high:
  - T1: ack pulse and first ROM issue.
  - T2: first rvalid.
- A burst of L=len+1 words issues in cycles T1..TL and returns in T2..TL+1. rlast is set at TL+1.
- One mandatory IDLE cycle separates bursts. Sustained throughput is L words per L+1 cycles.
- busy = (state==BURST) | issue_q.
- Worst-case wait for a request held continuously is (NREQ−1)×(2^LEN_W+1) cycles.

## Structure
- Package rom_sched_pkg holds:
  - typedef enum state_t {IDLE, BURST};
  - default LEN_W;
  - a helper function for one-hot from id.
- One natural sub-module, rr_pick: combinational round-robin picker taking req vector and pointer, producing winner index and any-valid flag.
- Everything else lives in rom_burst_sched. The ROM itself is instantiated by the parent, not here.

## Test plan
- Single requester: req[2], addr=0x010, len=3.
  - ack[2] at T1.
  - rom_addr_b 0x010..0x013 in T1..T4.
  - rvalid[2] in T2..T5 with rdata = ROM[0x010..0x013].
  - rlast only at T5.
- All four requesting from reset, len=0 each:
  - grants in order 0,1,2,3.
  - Re-requesting 1 and 3 then grants 1, then 3, respecting rr_q.
- Wrap: addr=2046, len=3 → rom_addr_b 2046, 2047, 0, 1.
- req[0] dropped at T2 of a len=7 burst → all 8 words still return, rlast on the 8th.
- rst_n low at T3 of a len=7 burst:
  - next cycle all outputs 0 and no rvalid.
  - after release, a pending req[1] is granted first, since rr_q=0 and req[0] is low.
- Back-to-back: req[0] and req[1] held high, len=1:
  - ack[0] at T1, ack[1] at T4.
  - rvalid never overlaps between requesters.
